// File: rtl/icache_axi_rd_bridge_pkg.sv
// Shared encodings for the ICache refill-to-AXI read bridge.
// AXI burst/response codes, FSM state values and the arsize helper.
package icache_axi_rd_bridge_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] RRESP_OKAY   = 2'd0;
    localparam logic [1:0] RRESP_EXOKAY = 2'd1;
    localparam logic [1:0] RRESP_SLVERR = 2'd2;
    localparam logic [1:0] RRESP_DECERR = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    function automatic logic [2:0] axi_size(int unsigned width_bits);
        return 3'($clog2(width_bits / 8));
    endfunction

endpackage

// File: rtl/icache_axi_rd_bridge_if.sv
// AXI4 read-address / read-data channel bundle between the bridge and the interconnect.
interface icache_axi_rd_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
);
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [ID_WIDTH-1:0]   arid;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [ID_WIDTH-1:0]   rid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/icache_axi_rd_bridge.sv
// Turns one ICache refill request into a single AXI4 INCR read burst and
// forwards each R beat back as a one-cycle ready/data pulse.
module icache_axi_rd_bridge
    import icache_axi_rd_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned AXI_ID     = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [7:0]            req_len_i,
    output logic                  req_ready_o,
    output logic [DATA_WIDTH-1:0] req_data_o,
    output logic                  req_last_o,
    output logic                  req_err_o,
    icache_axi_rd_bridge_if.master axi
);

    localparam logic [ID_WIDTH-1:0] AR_ID   = ID_WIDTH'(AXI_ID);
    localparam logic [2:0]          AR_SIZE = axi_size(DATA_WIDTH);

    logic [1:0]            state_q,   state_d;
    logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;
    logic [7:0]            arlen_q,   arlen_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q,  rready_d;
    logic                  err_q,     err_d;
    logic [7:0]            cnt_q,     cnt_d;

    logic beat, cnt_at_len, burst_end, beat_err;

    assign beat       = (state_q == ST_DATA) && rready_q && axi.rvalid;
    assign cnt_at_len = (cnt_q == arlen_q);
    // A missing rlast still terminates the burst on beat arlen+1.
    assign burst_end  = beat && (axi.rlast || cnt_at_len);
    assign beat_err   = beat && ((axi.rresp != RRESP_OKAY) || (axi.rid != AR_ID) ||
                                 (axi.rlast != cnt_at_len));

    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        err_d     = err_q || beat_err;
        cnt_d     = beat ? cnt_q + 8'd1 : cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    araddr_d  = req_addr_i;
                    arlen_d   = req_len_i;
                    arvalid_d = 1'b1;
                    err_d     = 1'b0;
                    cnt_d     = 8'd0;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (burst_end) begin
                    rready_d = 1'b0;
                    state_d  = ST_HOLD;
                end
            end
            // Cache still holds valid here; skipping one cycle avoids a duplicate AR.
            ST_HOLD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            araddr_q  <= '0;
            arlen_q   <= 8'd0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = arlen_q;
    assign axi.arid    = AR_ID;
    assign axi.arsize  = AR_SIZE;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.rready  = rready_q;

    assign req_ready_o = beat;
    assign req_data_o  = beat ? axi.rdata : '0;
    assign req_last_o  = burst_end;
    assign req_err_o   = err_q;

    req_valid_held_a: assert property (@(posedge clock) disable iff (reset)
        (state_q == ST_ADDR || state_q == ST_DATA) |-> req_valid_i)
        else $error("req_valid_i dropped during an active burst");

endmodule

// File: doc/icache_axi_rd_bridge.md
Name: icache_axi_rd_bridge

Overview:
Downstream neighbour of the instruction cache. It converts the cache's simple refill request (valid, line address, burst length) into one AXI4 INCR read burst on the AR/R channels. It returns each beat to the cache as a single-cycle ready/data pulse and marks the final beat with last. It sits between the ICache refill port and the instruction-side AXI master port of the SoC interconnect.

Parameters:
ADDR_WIDTH, 32, request and AXI address width
DATA_WIDTH, 32, beat width; AXI arsize is derived from this value
ID_WIDTH, 4, AXI ID width
AXI_ID, 0, constant arid driven on every burst; rid is checked against it

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
req_valid_i  in  1  refill request; held high by the cache until it sees last
req_addr_i  in  ADDR_WIDTH  line-aligned start address
req_len_i  in  8  AXI burst length minus one (cache drives 3 = 4 beats)
req_ready_o  out  1  one-cycle pulse per accepted beat
req_data_o  out  DATA_WIDTH  beat data; valid only when req_ready_o=1
req_last_o  out  1  high with req_ready_o on the final beat
req_err_o  out  1  sticky burst error
axi_arvalid_o  out  1  AR valid
axi_arready_i  in  1  AR ready
axi_araddr_o  out  ADDR_WIDTH  AR address
axi_arid_o  out  ID_WIDTH  AR id
axi_arlen_o  out  8  AR length
axi_arsize_o  out  3  log2(DATA_WIDTH/8)
axi_arburst_o  out  2  constant 2'b01 (INCR)
axi_rvalid_i  in  1  R valid
axi_rready_o  out  1  R ready
axi_rdata_i  in  DATA_WIDTH  R data
axi_rresp_i  in  2  R response
axi_rlast_i  in  1  R last
axi_rid_i  in  ID_WIDTH  R id

Behaviour:
- The FSM has four states: IDLE, ADDR, DATA, HOLD.
- Reset: state=IDLE; axi_arvalid_o=0, axi_rready_o=0, req_ready_o=0, req_last_o=0, req_err_o=0, req_data_o=0; axi_araddr_o/axi_arlen_o=0; beat counter=0.
- IDLE, req_valid_i=1 (next cycle):
  - latch req_addr_i into axi_araddr_o and req_len_i into axi_arlen_o;
  - assert axi_arvalid_o; clear req_err_o and the beat counter;
  - go to ADDR.
- ADDR: hold AR fields stable while arvalid is high (AXI rule). On axi_arready_i=1, next cycle drop arvalid, raise axi_rready_o, and go to DATA. AR latency is therefore at least 1 cycle after the request.
- DATA: axi_rready_o=1. A beat is a cycle with axi_rvalid_i & axi_rready_o.
  - On a beat, the same cycle (combinational): req_ready_o=1, req_data_o=axi_rdata_i, and req_last_o=axi_rlast_i.
  - The beat counter increments by 1 per beat and is 8 bits wide; it never wraps in a legal burst.
- Burst end: a beat with axi_rlast_i=1 ends the burst. Next cycle rready=0 and the state goes to HOLD.
- Error detection: req_err_o is set (next cycle, sticky) when any of these occur on a beat:
  - axi_rresp_i != 0;
  - axi_rid_i != AXI_ID;
  - axi_rlast_i=1 while counter != arlen (early last);
  - counter == arlen without axi_rlast_i (missing last).
- Missing last: the bridge still asserts req_last_o on beat arlen+1 and ends the burst. Later stray R beats are ignored (rready=0).
- HOLD: exactly one cycle, then IDLE. req_valid_i is ignored here because the cache drops valid one registered cycle after last. This state prevents a duplicate AR.
- Outside DATA: req_ready_o=0 and req_last_o=0. req_data_o is don't-care but must be driven 0 to keep traces clean.
- Mid-burst reset: all state returns to reset values in the next cycle. Stray R beats arriving after that are not acknowledged. The interconnect is reset by the same signal.
- req_valid_i dropping in ADDR or DATA is illegal cache behaviour. The burst still completes; a simulation-only assertion flags it.
- Only one outstanding burst exists at a time; there is no AR pipelining.

Decomposition:
- Shared package/define file:
  - AXI burst encodings (INCR=2'b01);
  - RRESP codes (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3);
  - FSM state encodings, 2 bits: IDLE=0, ADDR=1, DATA=2, HOLD=3.
- No sub-module is needed; the block is a single FSM plus a counter and an error flag.

Test Plan:
- Normal refill: req_addr=0x3000_0040, len=3, arready after 2 cycles, 4 OKAY beats 0x11,0x22,0x33,0x44 with rlast on the 4th -> one AR (addr 0x3000_0040, arlen 3, arsize 2, arburst 1), 4 req_ready pulses with matching data, req_last only on 0x44, err=0, HOLD then IDLE.
- R backpressure gaps: rvalid toggling 1,0,0,1,1,0,1 -> exactly 4 ready pulses, each coincident with rvalid, and data in order.
- Valid held through HOLD: req_valid_i stays high one cycle after last -> no second arvalid; a new request only after valid re-rises from IDLE.
- SLVERR on beat 2 -> req_err_o=1 from the following cycle through burst end; all 4 beats are still forwarded; err clears on the next request.
- Early rlast on beat 2 of len=3 -> req_last_o on beat 2, err=1, return to IDLE.
- Missing rlast on beat 4 -> req_last_o on beat 4, err=1; a 5th rvalid is not acknowledged.
- Reset asserted in DATA after beat 1 -> all outputs at reset values the next cycle, state IDLE, rready=0.
